// File: rtl/uart_defs_pkg.sv
// Shared definitions for the UART transmit path.
//   uart_state_t       : transmit FSM state encoding (IDLE/START/DATA/STOP)
//   DATA_BITS          : payload bits per frame (8N1)
//   STOP_BITS          : stop bits per frame
//   BAUD_SCALE_DEFAULT : clk cycles per bit for 100 MHz / 9600 baud
//   BAUD_SCALE_SIM     : short bit time used in simulation
package uart_defs;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS          = 8;
    localparam int STOP_BITS          = 1;
    localparam int BAUD_SCALE_DEFAULT = 10416;
    localparam int BAUD_SCALE_SIM     = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority rotation.
//   req    : per-client request vector
//   last   : index of the most recently granted client (lowest priority now)
//   enable : when low, no grant is produced
//   grant  : one-hot winner (all zero when nothing is requested or disabled)
//   id     : encoded index of the winner (0 when grant is zero)
// The pointer register itself lives in the parent.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    id
);

    logic            found;
    logic [ID_W-1:0] idx;

    // Search last+1, last+2, ... wrapping modulo NUM_REQ; the first hit wins,
    // so the client just served is examined last.
    always_comb begin
        grant = '0;
        id    = '0;
        found = 1'b0;
        idx   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = ID_W'((int'(last) + off) % NUM_REQ);
            if (enable && !found && req[idx]) begin
                grant[idx] = 1'b1;
                id         = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one 8N1 UART transmit line between NUM_REQ byte-producing clients.
//   clk        : system clock
//   reset      : asynchronous active-high reset
//   req        : per-client level request, held by the client until granted
//   data       : byte for client i on data[8*i+7:8*i], sampled in the grant cycle
//   grant      : one-hot one-cycle pulse marking the cycle the byte is captured
//   txd        : serial line, idle high
//   busy       : high while a frame is on the line
//   active_id  : client owning the current or most recent frame
//   frame_done : one-cycle pulse in the last clock of the stop bit
//   state_dbg  : current FSM state, for observation only
//
// Handshake: a client raises req[i] with its byte on data and holds both until
// it sees grant[i]; the byte is captured in that grant cycle, after which req
// and data may change freely. Grants are only issued from IDLE.
//
// All outputs are registered from next-state values, so txd trails the FSM
// state by one clock: the state enters START in the grant cycle T and the
// start bit appears on txd from T+1.
module uart_tx_arbiter
    import uart_defs::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int BAUD_SCALE = BAUD_SCALE_DEFAULT,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   data,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   txd,
    output logic                   busy,
    output logic [ID_W-1:0]        active_id,
    output logic                   frame_done,
    output uart_state_t            state_dbg
);

    localparam int CNT_W = $clog2(BAUD_SCALE);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAUD_SCALE - 1);

    uart_state_t       state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [2:0]        bit_idx, bit_next;
    logic [7:0]        shreg, shreg_next;
    logic [ID_W-1:0]   last, last_next;
    logic [ID_W-1:0]   id_next;
    logic [NUM_REQ-1:0] grant_next;
    logic              txd_next, busy_next, frame_done_next;

    logic [NUM_REQ-1:0] arb_grant;
    logic [ID_W-1:0]    arb_id;
    logic               bit_end;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .req    (req),
        .last   (last),
        .enable (state == IDLE),
        .grant  (arb_grant),
        .id     (arb_id)
    );

    assign bit_end   = (cnt == CNT_MAX);
    assign state_dbg = state;

    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        bit_next        = bit_idx;
        shreg_next      = shreg;
        last_next       = last;
        id_next         = active_id;
        grant_next      = '0;
        txd_next        = 1'b1;
        busy_next       = (state != IDLE);
        frame_done_next = 1'b0;

        // Bit-time counter runs continuously outside IDLE and wraps at CNT_MAX.
        if (state != IDLE) begin
            cnt_next = bit_end ? '0 : cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                if (|arb_grant) begin
                    grant_next = arb_grant;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (arb_grant[i]) begin
                            shreg_next = data[8*i +: 8];
                        end
                    end
                    id_next    = arb_id;
                    last_next  = arb_id;
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                txd_next = 1'b0;
                if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                txd_next = shreg[0];
                if (bit_end) begin
                    shreg_next = shreg >> 1;
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
                        bit_next   = '0;
                        state_next = STOP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                txd_next = 1'b1;
                if (bit_end) begin
                    if (bit_idx == 3'(STOP_BITS - 1)) begin
                        frame_done_next = 1'b1;
                        bit_next        = '0;
                        state_next      = IDLE;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Reset abandons any frame in flight: line goes high at once and the
    // pointer returns to NUM_REQ-1 so client 0 is served first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            last       <= ID_W'(NUM_REQ - 1);
            active_id  <= '0;
            grant      <= '0;
            txd        <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            bit_idx    <= bit_next;
            shreg      <= shreg_next;
            last       <= last_next;
            active_id  <= id_next;
            grant      <= grant_next;
            txd        <= txd_next;
            busy       <= busy_next;
            frame_done <= frame_done_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with NUM_REQ=4, BAUD_SCALE=4.
module tb_uart_tx_arbiter;
  import uart_defs::*;

  localparam int NUM_REQ    = 4;
  localparam int BAUD_SCALE = BAUD_SCALE_SIM;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] data = '0;
  logic [3:0]  grant;
  logic        txd;
  logic        busy;
  logic [1:0]  active_id;
  logic        frame_done;
  uart_state_t state_dbg;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .BAUD_SCALE(BAUD_SCALE)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .data       (data),
    .grant      (grant),
    .txd        (txd),
    .busy       (busy),
    .active_id  (active_id),
    .frame_done (frame_done),
    .state_dbg  (state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    data  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Waits (bounded) for any grant; current cycle is examined first.
  task automatic wait_grant(input string tag, input logic [3:0] exp_g, output int t_g);
    int n = 0;
    while (grant === 4'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, " grant"}, 32'(grant), 32'(exp_g));
    t_g = cyc;
  endtask

  // Follows one frame from its grant cycle T through T+41, decoding txd in
  // the middle of every bit.
  task automatic run_frame(input string tag, input logic [3:0] exp_g, input logic [7:0] exp_byte,
                           input logic [1:0] exp_id, input bit drop, input logic [3:0] pulse,
                           input bit change_data, output int t_g);
    logic [7:0] rx_byte = '0;
    logic       start_bit = 1'b1;
    logic       stop_bit = 1'b0;
    logic       all_busy = 1'b1;
    logic       any_fd = 1'b0;
    logic       any_grant = 1'b0;
    int         k;
    wait_grant(tag, exp_g, t_g);
    check({tag, " active_id"}, 32'(active_id), 32'(exp_id));
    check({tag, " busy at grant"}, 32'(busy), 32'd0);
    if (drop) req = req & ~exp_g;
    for (int c = 1; c <= 39; c++) begin
      @(negedge clk);
      if (change_data && c == 1) data = '1;
      if (c == 2) req = req | pulse;
      if (c == 3) req = req & ~pulse;
      all_busy  = all_busy & busy;
      any_fd    = any_fd | frame_done;
      any_grant = any_grant | (|grant);
      if (c % 4 == 2) begin
        k = c / 4;
        if (k == 0) start_bit = txd;
        else if (k == 9) stop_bit = txd;
        else rx_byte[k-1] = txd;
      end
    end
    check({tag, " start bit"}, 32'(start_bit), 32'd0);
    check({tag, " byte"}, 32'(rx_byte), 32'(exp_byte));
    check({tag, " stop bit"}, 32'(stop_bit), 32'd1);
    check({tag, " busy during frame"}, 32'(all_busy), 32'd1);
    check({tag, " early frame_done"}, 32'(any_fd), 32'd0);
    check({tag, " grant while busy"}, 32'(any_grant), 32'd0);
    @(negedge clk);  // T+40
    check({tag, " frame_done at T+40"}, 32'(frame_done), 32'd1);
    check({tag, " busy at T+40"}, 32'(busy), 32'd1);
    @(negedge clk);  // T+41
    check({tag, " busy at T+41"}, 32'(busy), 32'd0);
    check({tag, " frame_done at T+41"}, 32'(frame_done), 32'd0);
    check({tag, " txd idle at T+41"}, 32'(txd), 32'd1);
  endtask

  initial begin
    int t0, t1;
    logic any_fd;
    logic any_g;

    // 1: reset values, single client 1 sending 0x55
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset txd", 32'(txd), 32'd1);
    check("reset grant", 32'(grant), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset frame_done", 32'(frame_done), 32'd0);
    check("reset active_id", 32'(active_id), 32'd0);
    check("reset state", 32'(state_dbg), 32'(IDLE));
    reset = 1'b0;
    @(negedge clk);
    req = 4'b0010;
    data[15:8] = 8'h55;
    run_frame("t1", 4'b0010, 8'h55, 2'd1, 1'b1, 4'b0, 1'b0, t0);

    // 2: all four requesting, rotation 0,1,2,3,0 at 41-cycle spacing
    do_reset();
    data = 32'hA3A2A1A0;
    req  = 4'b1111;
    run_frame("t2 f0", 4'b0001, 8'hA0, 2'd0, 1'b0, 4'b0, 1'b0, t0);
    run_frame("t2 f1", 4'b0010, 8'hA1, 2'd1, 1'b0, 4'b0, 1'b0, t1);
    check("t2 gap 0-1", 32'(t1 - t0), 32'd41);
    run_frame("t2 f2", 4'b0100, 8'hA2, 2'd2, 1'b0, 4'b0, 1'b0, t0);
    check("t2 gap 1-2", 32'(t0 - t1), 32'd41);
    run_frame("t2 f3", 4'b1000, 8'hA3, 2'd3, 1'b0, 4'b0, 1'b0, t1);
    check("t2 gap 2-3", 32'(t1 - t0), 32'd41);
    run_frame("t2 f4", 4'b0001, 8'hA0, 2'd0, 1'b0, 4'b0, 1'b0, t0);
    check("t2 gap 3-0", 32'(t0 - t1), 32'd41);

    // 3: clients 0 and 2 alternate
    do_reset();
    data = 32'h00220011;
    req  = 4'b0101;
    run_frame("t3 f0", 4'b0001, 8'h11, 2'd0, 1'b0, 4'b0, 1'b0, t0);
    run_frame("t3 f1", 4'b0100, 8'h22, 2'd2, 1'b0, 4'b0, 1'b0, t0);
    run_frame("t3 f2", 4'b0001, 8'h11, 2'd0, 1'b0, 4'b0, 1'b0, t0);

    // 4: reset mid-DATA abandons the frame; priority restarts at client 0
    do_reset();
    data = 32'h96000000;
    req  = 4'b1000;
    wait_grant("t4 pre", 4'b1000, t0);
    repeat (15) @(negedge clk);
    check("t4 busy before reset", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("t4 txd on reset", 32'(txd), 32'd1);
    check("t4 busy on reset", 32'(busy), 32'd0);
    check("t4 grant on reset", 32'(grant), 32'd0);
    any_fd = 1'b0;
    repeat (3) begin
      @(negedge clk);
      any_fd = any_fd | frame_done;
    end
    check("t4 no frame_done in reset", 32'(any_fd), 32'd0);
    req  = 4'b1010;
    data = 32'h96005A00;
    reset = 1'b0;
    run_frame("t4 post", 4'b0010, 8'h5A, 2'd1, 1'b1, 4'b0, 1'b0, t0);

    // 5: after client 3, simultaneous 0 and 3 -> client 0 via wrap
    do_reset();
    data = 32'hC3000000;
    req  = 4'b1000;
    run_frame("t5 f3", 4'b1000, 8'hC3, 2'd3, 1'b1, 4'b0, 1'b0, t0);
    data = 32'hC3000081;
    req  = 4'b1001;
    run_frame("t5 wrap", 4'b0001, 8'h81, 2'd0, 1'b1, 4'b0, 1'b0, t0);

    // 6: data change after grant ignored; short mid-frame req pulse not served
    do_reset();
    data = 32'h0000003C;
    req  = 4'b0001;
    run_frame("t6", 4'b0001, 8'h3C, 2'd0, 1'b1, 4'b0100, 1'b1, t0);
    any_g = 1'b0;
    any_fd = 1'b0;
    repeat (20) begin
      @(negedge clk);
      any_g = any_g | (|grant) | busy;
      any_fd = any_fd | frame_done;
    end
    check("t6 dropped pulse not granted", 32'(any_g), 32'd0);
    check("t6 no stray frame_done", 32'(any_fd), 32'd0);
    check("t6 line idle", 32'(txd), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
